pingpong_frame_ctrl: RTL and testbench
======================================

PINGPONG_FRAME_CTRL -- requirements
Module: pingpong_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, buffer address width; 2*IMG_W*IMG_H <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameters IMG_W and IMG_H, default 16 each; FRAME = IMG_W*IMG_H pixels per bank.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid&in_ready
- in_data  in  DATA_WIDTH  input pixel, raster order
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  output pixel
- out_last  out  1  high with final pixel of a frame
- mem_wr_en  out  1  to buffer write port
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  DATA_WIDTH  write data
- mem_rd_en  out  1  to buffer read port
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_data  in  DATA_WIDTH  read data, valid one cycle after mem_rd_en
- bank_full  out  2  per-bank frame-complete flags

Function
REQ-005 SHALL drive the external two-bank buffer: bank b occupies addresses b*FRAME .. b*FRAME+FRAME-1.
REQ-006 Write side SHALL hold wr_bank and wr_cnt; in_ready = ~bank_full[wr_bank], combinational.
REQ-007 On accept: mem_wr_en=1, mem_wr_addr=wr_bank*FRAME+wr_cnt, mem_wr_data=in_data, same cycle (combinational, no added latency); wr_cnt increments.
REQ-008 On accept with wr_cnt==FRAME-1: wr_cnt<=0, bank_full[wr_bank]<=1, wr_bank toggles.
REQ-009 Read side SHALL hold rd_bank and rd_cnt; issue read (mem_rd_en=1, mem_rd_addr=rd_bank*FRAME+rd_cnt) only when bank_full[rd_bank]=1 and fifo occupancy + in-flight reads < 2.
REQ-010 Read data SHALL be captured into a 2-entry output FIFO one cycle after issue, tagged with last = (issued rd_cnt==FRAME-1).
REQ-011 On issuing rd_cnt==FRAME-1: rd_cnt<=0, bank_full[rd_bank]<=0, rd_bank toggles; bank becomes writable on next cycle.
REQ-012 out_valid = FIFO non-empty; out_data/out_last = FIFO head; pop on out_valid&out_ready; no pixel lost or duplicated under any out_ready pattern.
REQ-013 Sustained throughput SHALL be one pixel/cycle in and out when out_ready=1 and banks alternate.
REQ-014 Set of bank_full by writer and clear by reader in same cycle SHALL both take effect (always different banks).
REQ-015 Both banks full: in_ready=0 until reader finishes issuing its bank; input stalls, never overwrites.
REQ-016 Output order SHALL equal input order, frames strictly alternating bank 0, 1, 0, ...
REQ-017 Counters SHALL wrap only per REQ-008/REQ-011; ADDR_WIDTH arithmetic, no overflow for legal parameters.

Reset
REQ-018 On rst: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00, FIFO empty, in-flight read discarded.
REQ-019 Reset outputs: in_ready=1 (after first cycle), out_valid=0, out_last=0, mem_wr_en=0, mem_rd_en=0, out_data=0.
REQ-020 rst mid-frame SHALL abandon partial frames; first frame after reset writes bank 0 from address 0.

Structure
REQ-021 FRAME-size/bank-base helper constants SHALL live in shared package pp_buf_pkg.
REQ-022 Output FIFO SHALL be sub-module pp_out_fifo (2-entry, DATA_WIDTH+1 wide, valid/ready).

Verification (IMG_W=4, IMG_H=2, FRAME=8)
REQ-023 Stream 8 pixels 0x10..0x17, out_ready=1 -> writes addr 0..7, bank_full=01, reads addr 0..7, output 0x10..0x17, out_last only on 0x17.
REQ-024 Continuous 3 frames, out_ready=1 -> addresses 0-7, 8-15, 0-7; no bubbles after first frame; order preserved.
REQ-025 out_ready=0 while 3 frames offered -> bank_full=11, in_ready=0 after 16 accepts, mem_rd_en at most 2 issues; release -> all 24 pixels out in order.
REQ-026 Random out_ready (50%) over 10 frames -> scoreboard match, no duplicates, out_last every 8th pixel.
REQ-027 rst asserted after 5 pixels of frame 1 and while output FIFO holds data -> all outputs to reset values, next frame written at addr 0, no stale pixels emitted.

Source files
------------

// File: rtl/pp_buf_pkg.sv
// Shared constants and address helpers for the two-bank ping-pong frame buffer.
package pp_buf_pkg;

    localparam int NUM_BANKS = 2;

    function automatic int frame_size(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    function automatic int bank_base(input int bank, input int frame);
        return bank * frame;
    endfunction

endpackage

// File: rtl/pp_out_fifo.sv
// Two-entry valid/ready FIFO holding {last, pixel} between buffer reads and the output port.
module pp_out_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    // Head is forced to zero when empty so the output port idles at a clean value.
    assign pop_data   = pop_valid ? mem[rd_ptr] : '0;
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame buffer controller: writer fills one bank while the reader drains the other.
module pingpong_frame_ctrl
    import pp_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [1:0]            bank_full
);

    localparam int FRAME = frame_size(IMG_W, IMG_H);
    localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(FRAME - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE0    = ADDR_WIDTH'(bank_base(0, FRAME));
    localparam logic [ADDR_WIDTH-1:0] BASE1    = ADDR_WIDTH'(bank_base(1, FRAME));

    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic                  accept;
    logic                  issue;
    logic                  wr_last;
    logic                  rd_last;
    logic                  rd_inflight;
    logic                  rd_inflight_last;
    logic                  fifo_push_ready;
    logic                  fifo_pop;
    logic [1:0]            fifo_occ;
    logic [2:0]            slots_used;
    logic [1:0]            set_mask;
    logic [1:0]            clr_mask;

    assign in_ready    = ~bank_full[wr_bank];
    assign accept      = in_valid & in_ready & ~rst;
    assign wr_last     = (wr_cnt == LAST_CNT);
    assign mem_wr_en   = accept;
    assign mem_wr_addr = (wr_bank ? BASE1 : BASE0) + wr_cnt;
    assign mem_wr_data = in_data;

    // Occupancy is recovered from the FIFO handshake flags; counting this cycle's pop
    // keeps reads back-to-back while the consumer is draining.
    assign fifo_pop   = out_valid & out_ready;
    assign fifo_occ   = ~fifo_push_ready ? 2'd2 : {1'b0, out_valid};
    assign slots_used = {1'b0, fifo_occ} + {2'b00, rd_inflight} - {2'b00, fifo_pop};
    assign issue      = bank_full[rd_bank] & ~rst & (slots_used < 3'd2);
    assign rd_last    = (rd_cnt == LAST_CNT);
    assign mem_rd_en  = issue;
    assign mem_rd_addr = (rd_bank ? BASE1 : BASE0) + rd_cnt;

    assign set_mask = (accept & wr_last) ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask = (issue & rd_last)  ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank          <= 1'b0;
            rd_bank          <= 1'b0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            bank_full        <= 2'b00;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else begin
            if (accept) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (issue) begin
                if (rd_last) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
            // Writer and reader always own different banks, so set and clear never collide.
            bank_full        <= (bank_full & ~clr_mask) | set_mask;
            rd_inflight      <= issue;
            rd_inflight_last <= issue & rd_last;
        end
    end

    pp_out_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (rd_inflight),
        .push_ready (fifo_push_ready),
        .push_data  ({rd_inflight_last, mem_rd_data}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   ({out_last, out_data})
    );

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Randomized bench for pingpong_frame_ctrl with a frame-count reference model and literal pins.
module tb_pingpong_frame_ctrl;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int FR = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [1:0]    bank_full;

    always #5 clk = ~clk;

    pingpong_frame_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMG_W      (4),
        .IMG_H      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .bank_full   (bank_full)
    );

    // External buffer: one-cycle read latency, junk on idle cycles.
    logic [DW-1:0] mem [0:2*FR-1];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr[3:0]] <= mem_wr_data;
        mem_rd_data <= mem_rd_en ? mem[mem_rd_addr[3:0]] : DW'($urandom);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int acc_n, iss_n, pop_n, cyc;
    logic [DW:0] exp_q [$];
    logic [DW-1:0] next_pix;
    logic rst_prev = 1'b0;
    int wr_addr_log [$];
    int rd_addr_log [$];
    int out_log [$];
    int last_log [$];
    int first_out, last_out, first_wr, last_wr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        rd_addr_log.delete();
        out_log.delete();
        last_log.delete();
        first_out = -1; last_out = -1; first_wr = -1; last_wr = -1;
    endtask

    task automatic cycle(input logic v, input logic r, input logic rs);
        int pend, rd_done;
        logic do_wr, do_rd, do_pop, rst_s;
        logic [AW-1:0] wa, ra;
        logic [1:0] bf_exp;
        @(negedge clk);
        rst = rs; in_valid = v; in_data = next_pix; out_ready = r;
        #1;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_wr_en", mem_wr_en, 0);
                chk("rst_rd_en", mem_rd_en, 0);
                chk("rst_in_ready", in_ready, 1);
            end
        end else begin
            rd_done = iss_n / FR;
            pend    = acc_n / FR - rd_done;
            bf_exp  = (pend == 0) ? 2'b00 : (pend == 2) ? 2'b11 : 2'(2'b01 << (rd_done % 2));
            chk("in_ready", in_ready, pend < 2);
            chk("bank_full", bank_full, bf_exp);
            chk("wr_en", mem_wr_en, v && pend < 2);
            if (mem_wr_en) begin
                chk("wr_addr", mem_wr_addr, ((acc_n / FR) % 2) * FR + acc_n % FR);
                chk("wr_data", mem_wr_data, next_pix);
            end
            if (mem_rd_en) begin
                chk("rd_has_frame", pend > 0, 1);
                chk("rd_addr", mem_rd_addr, ((iss_n / FR) % 2) * FR + iss_n % FR);
                chk("rd_window", (iss_n - pop_n - int'(out_valid & out_ready)) < 2, 1);
            end
            if (out_valid) begin
                chk("out_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("out_data", out_data, exp_q[0][DW-1:0]);
                    chk("out_last", out_last, exp_q[0][DW]);
                end
            end
        end
        do_wr = mem_wr_en; do_rd = mem_rd_en; do_pop = out_valid & out_ready; rst_s = rst;
        wa = mem_wr_addr; ra = mem_rd_addr;
        @(posedge clk);
        if (rst_s) begin
            acc_n = 0; iss_n = 0; pop_n = 0;
            exp_q.delete();
        end else begin
            if (do_wr) begin
                exp_q.push_back({(acc_n % FR) == FR - 1, next_pix});
                acc_n++;
                next_pix++;
                wr_addr_log.push_back(int'(wa));
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (do_rd) begin
                iss_n++;
                rd_addr_log.push_back(int'(ra));
            end
            if (do_pop && exp_q.size() != 0) begin
                out_log.push_back(int'(exp_q[0][DW-1:0]));
                last_log.push_back(int'(exp_q[0][DW]));
                void'(exp_q.pop_front());
                pop_n++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
        rst_prev = rst_s;
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        clear_logs();
    endtask

    task automatic drain(input int n, input int budget);
        for (int i = 0; i < budget && pop_n < n; i++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int bad_idx, nlast;
        cyc = 0; acc_n = 0; iss_n = 0; pop_n = 0; next_pix = '0;
        clear_logs();

        // Single frame, ready downstream.
        do_reset();
        next_pix = 8'h10;
        for (int i = 0; i < 20 && acc_n < 8; i++) cycle(1'b1, 1'b1, 1'b0);
        #1;
        chk("t1_bank_full_after_frame", bank_full, 2'b01);
        drain(8, 40);
        chk("t1_out_count", out_log.size(), 8);
        bad_idx = 0;
        for (int i = 0; i < 8 && i < wr_addr_log.size() && i < rd_addr_log.size() && i < out_log.size(); i++) begin
            if (wr_addr_log[i] != i || rd_addr_log[i] != i || out_log[i] != 8'h10 + i || last_log[i] != (i == 7))
                bad_idx++;
        end
        chk("t1_addr_data_last_pins", bad_idx, 0);

        // Three back-to-back frames.
        do_reset();
        next_pix = 8'h20;
        for (int i = 0; i < 60 && acc_n < 24; i++) cycle(1'b1, 1'b1, 1'b0);
        drain(24, 60);
        chk("t2_out_count", out_log.size(), 24);
        bad_idx = 0;
        for (int i = 0; i < 24 && i < wr_addr_log.size() && i < out_log.size(); i++) begin
            if (wr_addr_log[i] != ((i >= 8 && i < 16) ? 8 + (i - 8) : i % 8) || out_log[i] != 8'h20 + i)
                bad_idx++;
        end
        chk("t2_addr_order_pins", bad_idx, 0);
        chk("t2_write_span", last_wr - first_wr, 23);
        chk("t2_output_span", last_out - first_out, 23);

        // Stalled consumer: both banks fill, input blocks, reads limited.
        do_reset();
        next_pix = 8'h40;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
        #1;
        chk("t3_accepts", acc_n, 16);
        chk("t3_bank_full", bank_full, 2'b11);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_issues", iss_n, 2);
        for (int i = 0; i < 100 && acc_n < 24; i++) cycle(1'b1, 1'b1, 1'b0);
        drain(24, 60);
        chk("t3_out_count", out_log.size(), 24);
        bad_idx = 0;
        for (int i = 0; i < out_log.size(); i++) if (out_log[i] != 8'h40 + i) bad_idx++;
        chk("t3_order_pins", bad_idx, 0);

        // Ten frames with random handshakes on both sides.
        do_reset();
        next_pix = 8'h00;
        for (int i = 0; i < 2000 && acc_n < 80; i++)
            cycle(($urandom % 4) != 0, $urandom % 2, 1'b0);
        for (int i = 0; i < 400 && pop_n < 80; i++) cycle(1'b0, $urandom % 2, 1'b0);
        chk("t4_out_count", out_log.size(), 80);
        nlast = 0; bad_idx = 0;
        for (int i = 0; i < out_log.size(); i++) begin
            if (out_log[i] != (i % 256)) bad_idx++;
            if (last_log[i] != 0) begin
                nlast++;
                if (i % 8 != 7) bad_idx++;
            end
        end
        chk("t4_last_count", nlast, 10);
        chk("t4_seq_pins", bad_idx, 0);

        // Reset mid-frame with data parked in the output FIFO.
        do_reset();
        next_pix = 8'h80;
        for (int i = 0; i < 40 && acc_n < 13; i++) cycle(1'b1, 1'b0, 1'b0);
        #1;
        chk("t5_fifo_holds", out_valid, 1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        clear_logs();
        next_pix = 8'hA0;
        for (int i = 0; i < 20 && acc_n < 8; i++) cycle(1'b1, 1'b1, 1'b0);
        drain(8, 40);
        chk("t5_out_count", out_log.size(), 8);
        chk("t5_first_wr_addr", wr_addr_log.size() != 0 ? wr_addr_log[0] : -1, 0);
        chk("t5_first_out", out_log.size() != 0 ? out_log[0] : -1, 8'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
